lsu_ctrl: RTL and testbench

- Load/store sequencer between the core datapath and a variable-latency data memory port with a req/gnt/rvld handshake.
- Consumes the decoder's mem-write enable and 5-bit access mask (bit4 = unsigned load, bits[3:0] = byte-lane pattern), plus the ALU address and rs2 data.
- Holds the pipeline with a stall until the access completes.
- Splits word-misaligned accesses into two aligned word transactions, merges the read data, and returns aligned, sign/zero-extended load data for writeback.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StDone
    } lsuState_t;

    localparam logic [4:0] MASK_B  = 5'b00001;
    localparam logic [4:0] MASK_H  = 5'b00011;
    localparam logic [4:0] MASK_W  = 5'b01111;
    localparam logic [4:0] MASK_BU = 5'b10001;
    localparam logic [4:0] MASK_HU = 5'b10011;

    function automatic logic mask_legal(input logic [4:0] mask);
        logic legal;
        case (mask)
            MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and shifted store data for two beats, plus
// extraction and sign/zero extension of load data from the merged beats.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [4:0]  mask,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0,
    input  logic [23:0] beat1,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] rdata
);

    logic [31:0] r32;
    logic        signExt;

    always_comb begin
        be8  = {4'b0000, mask[3:0]} << off;
        wd64 = {32'h0, wdata} << {off, 3'b000};

        // Only beat1 bytes 0..2 can ever land in the low word after the shift.
        unique case (off)
            2'd0: r32 = beat0;
            2'd1: r32 = {beat1[7:0],  beat0[31:8]};
            2'd2: r32 = {beat1[15:0], beat0[31:16]};
            2'd3: r32 = {beat1[23:0], beat0[31:24]};
            default: r32 = beat0;
        endcase

        signExt = ~mask[4];
        case (mask[3:0])
            4'b0001: rdata = {{24{signExt & r32[7]}},  r32[7:0]};
            4'b0011: rdata = {{16{signExt & r32[15]}}, r32[15:0]};
            default: rdata = r32;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: stalls the pipeline, splits misaligned accesses into
// two word beats on a req/gnt/rvld memory port, and returns extended load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_vld,
    input  logic              i_wr,
    input  logic [4:0]        i_mask,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvld,
    input  logic [31:0]       i_mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsuState_t         stateQ, stateD;
    logic [ADDR_W-3:0] baseQ;
    logic [1:0]        offQ;
    logic [4:0]        maskQ;
    logic [31:0]       wdataQ;
    logic              wrQ;
    logic              errQ;
    logic [31:0]       beat0Q;
    logic [23:0]       beat1Q;
    logic [CntW-1:0]   cntQ, cntD;

    logic        accept, cap0, cap1, toErr, memReq, beatSel, needBeat1, timeoutHit, doneSt;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] alignedRdata;

    lsu_align uAlign (
        .off   (offQ),
        .mask  (maskQ),
        .wdata (wdataQ),
        .beat0 (beat0Q),
        .beat1 (beat1Q),
        .be8   (be8),
        .wd64  (wd64),
        .rdata (alignedRdata)
    );

    assign needBeat1  = |be8[7:4];
    assign timeoutHit = (TIMEOUT != 0) && (32'(cntQ) == TIMEOUT - 1);
    assign beatSel    = (stateQ == StReq1) || (stateQ == StWait1);
    assign accept     = (stateQ == StIdle) && i_req_vld;

    always_comb begin
        stateD = stateQ;
        memReq = 1'b0;
        cap0   = 1'b0;
        cap1   = 1'b0;
        toErr  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (i_req_vld) stateD = mask_legal(i_mask) ? StReq0 : StDone;
            end
            StReq0, StReq1: begin
                memReq = 1'b1;
                if (i_mem_gnt) begin
                    if (i_mem_rvld) begin
                        cap0   = ~beatSel;
                        cap1   = beatSel;
                        stateD = (!beatSel && needBeat1) ? StReq1 : StDone;
                    end else begin
                        stateD = beatSel ? StWait1 : StWait0;
                    end
                end else if (timeoutHit) begin
                    toErr  = 1'b1;
                    stateD = StDone;
                end
            end
            StWait0, StWait1: begin
                if (i_mem_rvld) begin
                    cap0   = ~beatSel;
                    cap1   = beatSel;
                    stateD = (!beatSel && needBeat1) ? StReq1 : StDone;
                end else if (timeoutHit) begin
                    toErr  = 1'b1;
                    stateD = StDone;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
        cntD = (stateD != stateQ) ? '0 : cntQ + CntW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stateQ <= StIdle;
            baseQ  <= '0;
            offQ   <= '0;
            maskQ  <= '0;
            wdataQ <= '0;
            wrQ    <= 1'b0;
            errQ   <= 1'b0;
            beat0Q <= '0;
            beat1Q <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                baseQ  <= i_addr[ADDR_W-1:2];
                offQ   <= i_addr[1:0];
                maskQ  <= i_mask;
                wdataQ <= i_wdata;
                wrQ    <= i_wr;
                errQ   <= ~mask_legal(i_mask);
            end else if (toErr) begin
                errQ <= 1'b1;
            end
            if (cap0) beat0Q <= i_mem_rdata;
            if (cap1) beat1Q <= i_mem_rdata[23:0];
        end
    end

    assign doneSt      = (stateQ == StDone);
    assign o_done      = doneSt;
    assign o_err       = doneSt & errQ;
    assign o_rdata     = (doneSt && !errQ && !wrQ) ? alignedRdata : 32'h0;
    // Gated by reset so every output reads 0 while reset is held.
    assign o_stall     = ~i_reset & ((i_req_vld & (stateQ == StIdle)) |
                                     ((stateQ != StIdle) & (stateQ != StDone)));
    assign o_mem_req   = memReq;
    assign o_mem_addr  = memReq ? {(beatSel ? baseQ + 1'b1 : baseQ), 2'b00} : '0;
    assign o_mem_we    = memReq & wrQ;
    assign o_mem_be    = memReq ? (beatSel ? be8[7:4] : be8[3:0]) : 4'b0000;
    assign o_mem_wdata = memReq ? (beatSel ? wd64[63:32] : wd64[31:0]) : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_vld;
    logic        i_wr;
    logic [4:0]  i_mask;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvld;
    logic [31:0] i_mem_rdata;

    int nAsserts = 0;
    int nFail    = 0;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_vld   (i_req_vld),
        .i_wr        (i_wr),
        .i_mask      (i_mask),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .i_mem_gnt   (i_mem_gnt),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rvld  (i_mem_rvld),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [4:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata);
        i_req_vld = 1'b1;
        i_wr      = wr;
        i_mask    = mask;
        i_addr    = addr;
        i_wdata   = wdata;
        #1;
        chk("accept_stall", o_stall, 1);
        chk("accept_noreq", o_mem_req, 0);
        tick();
    endtask

    // Serves one beat: gntDly request cycles before the grant, rvld rvldDly cycles after it.
    task automatic beat(input string tag, input logic [31:0] eAddr, input logic [3:0] eBe,
                        input logic eWe, input logic [31:0] eWd, input int gntDly,
                        input int rvldDly, input logic [31:0] rd);
        for (int i = 0; i < gntDly; i++) begin
            #1;
            chk({tag, "_req_hold"}, o_mem_req, 1);
            tick();
        end
        i_mem_gnt = 1'b1;
        if (rvldDly == 0) begin
            i_mem_rvld  = 1'b1;
            i_mem_rdata = rd;
        end
        #1;
        chk({tag, "_req"}, o_mem_req, 1);
        chk({tag, "_addr"}, o_mem_addr, eAddr);
        chk({tag, "_be"}, o_mem_be, eBe);
        chk({tag, "_we"}, o_mem_we, eWe);
        chk({tag, "_stall"}, o_stall, 1);
        if (eWe) chk({tag, "_wdata"}, o_mem_wdata, eWd);
        tick();
        i_mem_gnt  = 1'b0;
        i_mem_rvld = 1'b0;
        if (rvldDly > 0) begin
            for (int i = 1; i < rvldDly; i++) begin
                #1;
                chk({tag, "_wait_noreq"}, o_mem_req, 0);
                tick();
            end
            i_mem_rvld  = 1'b1;
            i_mem_rdata = rd;
            #1;
            chk({tag, "_wait_stall"}, o_stall, 1);
            tick();
            i_mem_rvld = 1'b0;
        end
    endtask

    task automatic finish(input string tag, input logic [31:0] eRd, input logic eErr);
        #1;
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_err"}, o_err, eErr);
        chk({tag, "_rdata"}, o_rdata, eRd);
        chk({tag, "_stall_low"}, o_stall, 0);
        chk({tag, "_noreq"}, o_mem_req, 0);
        tick();
        i_req_vld = 1'b0;
        #1;
        chk({tag, "_done_clr"}, o_done, 0);
        chk({tag, "_idle_stall"}, o_stall, 0);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_req_vld   = 1'b0;
        i_wr        = 1'b0;
        i_mask      = 5'b0;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_gnt   = 1'b0;
        i_mem_rvld  = 1'b0;
        i_mem_rdata = 32'h0;
        tick();
        chk("rst_stall", o_stall, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_be", o_mem_be, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        i_reset = 1'b0;
        tick();

        // Aligned LW, grant after one cycle, rvld two cycles after grant
        issue(1'b0, 5'b01111, 32'h100, 32'h0);
        beat("lw", 32'h100, 4'b1111, 1'b0, 32'h0, 1, 2, 32'h8000_00FF);
        finish("lw", 32'h8000_00FF, 1'b0);

        // LB / LBU at byte 3
        issue(1'b0, 5'b00001, 32'h103, 32'h0);
        beat("lb", 32'h100, 4'b1000, 1'b0, 32'h0, 0, 0, 32'h8012_3456);
        finish("lb", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 5'b10001, 32'h103, 32'h0);
        beat("lbu", 32'h100, 4'b1000, 1'b0, 32'h0, 0, 1, 32'h8012_3456);
        finish("lbu", 32'h0000_0080, 1'b0);

        // Misaligned SW split into two beats
        issue(1'b1, 5'b01111, 32'h202, 32'hAABB_CCDD);
        beat("sw_b0", 32'h200, 4'b1100, 1'b1, 32'hCCDD_0000, 0, 1, 32'h0);
        beat("sw_b1", 32'h204, 4'b0011, 1'b1, 32'h0000_AABB, 1, 0, 32'h0);
        finish("sw", 32'h0, 1'b0);

        // Misaligned LH straddling a word boundary
        issue(1'b0, 5'b00011, 32'h3FF, 32'h0);
        beat("lh_b0", 32'h3FC, 4'b1000, 1'b0, 32'h0, 0, 0, 32'h11AA_BBCC);
        beat("lh_b1", 32'h400, 4'b0001, 1'b0, 32'h0, 0, 2, 32'hDDEE_FF22);
        finish("lh", 32'h0000_2211, 1'b0);

        // Misaligned LW wrapping past the top of the address space
        issue(1'b0, 5'b01111, 32'hFFFF_FFFE, 32'h0);
        beat("wrap_b0", 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 0, 0, 32'h5566_1234);
        beat("wrap_b1", 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 0, 0, 32'hABCD_7788);
        finish("wrap", 32'h7788_5566, 1'b0);

        // Illegal mask: no bus access, error pulse next cycle
        issue(1'b0, 5'b00111, 32'h100, 32'h0);
        finish("illegal", 32'h0, 1'b1);

        // Grant timeout: request held for four cycles, then error
        issue(1'b0, 5'b01111, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_gnt_req", o_mem_req, 1);
            tick();
        end
        finish("to_gnt", 32'h0, 1'b1);

        // rvld timeout, then a late rvld that must be ignored
        issue(1'b0, 5'b01111, 32'h600, 32'h0);
        i_mem_gnt = 1'b1;
        #1;
        chk("to_rvld_req", o_mem_req, 1);
        tick();
        i_mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_rvld_noreq", o_mem_req, 0);
            chk("to_rvld_stall", o_stall, 1);
            tick();
        end
        finish("to_rvld", 32'h0, 1'b1);
        i_mem_rvld  = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        i_mem_rvld = 1'b0;
        #1;
        chk("late_rvld_done", o_done, 0);
        chk("late_rvld_req", o_mem_req, 0);

        // Reset during WAIT1 of a split load
        issue(1'b0, 5'b00011, 32'h3FF, 32'h0);
        beat("rst_b0", 32'h3FC, 4'b1000, 1'b0, 32'h0, 0, 0, 32'h11AA_BBCC);
        #1;
        chk("rst_b1_req", o_mem_req, 1);
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        #1;
        chk("rst_wait1_stall", o_stall, 1);
        i_reset = 1'b1;
        #1;
        chk("rst_mid_stall", o_stall, 0);
        chk("rst_mid_req", o_mem_req, 0);
        chk("rst_mid_done", o_done, 0);
        chk("rst_mid_err", o_err, 0);
        chk("rst_mid_be", o_mem_be, 0);
        i_req_vld = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        issue(1'b0, 5'b01111, 32'h100, 32'h0);
        beat("post_rst", 32'h100, 4'b1111, 1'b0, 32'h0, 1, 1, 32'h1234_5678);
        finish("post_rst", 32'h1234_5678, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
